wb_master_arbiter: RTL and testbench



---
 rtl/wb_arb_pkg.sv | 16 +
 rtl/wb_rr_arbiter.sv | 37 +++
 rtl/wb_master_arbiter.sv | 166 ++++++++++++++++
 tb/tb_wb_master_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: FSM encoding,
// owner indices and the watchdog counter width.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN0  = 2'd1,
        ST_OWN1  = 2'd2,
        ST_ABORT = 2'd3
    } arb_state_t;

    localparam int OWNER_M0   = 0;
    localparam int OWNER_M1   = 1;
    localparam int WDOG_WIDTH = 16;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-way request arbiter: fixed priority to m0, or round-robin against the
// last master that was granted.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    logic last_m1;

    // The pointer advances when a grant is taken; it is only consulted in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_m1 <= 1'b0;
        end else if (update && (gnt != 2'b00)) begin
            last_m1 <= gnt[OWNER_M1];
        end
    end

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            if (FIXED_PRIORITY || last_m1) begin
                gnt = 2'b01;
            end else begin
                gnt = 2'b10;
            end
        end
    end

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master, one-slave Wishbone arbiter with whole-cycle grant holding and
// a watchdog that aborts a stalled slave and returns an error to the owner.
module wb_master_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [DATA_WIDTH-1:0] m0_dat_i,
    output logic [DATA_WIDTH-1:0] m0_dat_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_dat_i,
    output logic [DATA_WIDTH-1:0] m1_dat_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    input  logic                  s_ack_i,
    output logic [1:0]            gnt_o,
    output logic                  timeout_o
);

    localparam logic [WDOG_WIDTH-1:0] WDOG_LIMIT = WDOG_WIDTH'(TIMEOUT_CYCLES - 1);

    arb_state_t            state;
    arb_state_t            state_next;
    logic                  owner_m1;
    logic [WDOG_WIDTH-1:0] wdog;
    logic [1:0]            req;
    logic [1:0]            arb_gnt;
    logic                  owned;
    logic                  sel_m1;
    logic                  fire;
    logic                  own_cyc;
    logic                  own_stb;
    logic                  own_we;
    logic [ADDR_WIDTH-1:0] own_adr;
    logic [DATA_WIDTH-1:0] own_dat;

    assign req    = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
    assign owned  = (state == ST_OWN0) || (state == ST_OWN1);
    assign sel_m1 = (state == ST_OWN1) || ((state == ST_ABORT) && owner_m1);

    assign own_cyc = sel_m1 ? m1_cyc_i : m0_cyc_i;
    assign own_stb = sel_m1 ? m1_stb_i : m0_stb_i;
    assign own_we  = sel_m1 ? m1_we_i  : m0_we_i;
    assign own_adr = sel_m1 ? m1_adr_i : m0_adr_i;
    assign own_dat = sel_m1 ? m1_dat_i : m0_dat_i;

    // An ack arriving on the limit cycle wins over the timeout.
    assign fire = owned && own_stb && !s_ack_i && (wdog == WDOG_LIMIT);

    wb_rr_arbiter #(
        .FIXED_PRIORITY (FIXED_PRIORITY != 0)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .update ((state == ST_IDLE) && (req != 2'b00)),
        .gnt    (arb_gnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            owner_m1 <= 1'b0;
            wdog     <= '0;
        end else begin
            state <= state_next;
            if ((state == ST_IDLE) && (state_next != ST_IDLE)) begin
                owner_m1 <= (state_next == ST_OWN1);
            end
            if (owned && (state_next == state) && own_stb && !s_ack_i) begin
                wdog <= wdog + 1'b1;
            end else begin
                wdog <= '0;
            end
        end
    end

    always_comb begin
        state_next = state;
        gnt_o      = 2'b00;
        timeout_o  = 1'b0;
        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;
        s_we_o     = 1'b0;
        s_adr_o    = '0;
        s_dat_o    = '0;
        m0_dat_o   = '0;
        m0_ack_o   = 1'b0;
        m0_err_o   = 1'b0;
        m1_dat_o   = '0;
        m1_ack_o   = 1'b0;
        m1_err_o   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (arb_gnt[OWNER_M0]) begin
                    state_next = ST_OWN0;
                end else if (arb_gnt[OWNER_M1]) begin
                    state_next = ST_OWN1;
                end
            end
            ST_OWN0, ST_OWN1: begin
                gnt_o[OWNER_M0] = !sel_m1;
                gnt_o[OWNER_M1] = sel_m1;
                s_cyc_o = own_cyc;
                s_stb_o = own_stb;
                s_we_o  = own_we;
                s_adr_o = own_adr;
                s_dat_o = own_dat;
                if (sel_m1) begin
                    m1_dat_o = s_dat_i;
                end else begin
                    m0_dat_o = s_dat_i;
                end
                if (fire) begin
                    state_next = ST_ABORT;
                    timeout_o  = 1'b1;
                    if (sel_m1) begin
                        m1_err_o = 1'b1;
                    end else begin
                        m0_err_o = 1'b1;
                    end
                end else begin
                    if (sel_m1) begin
                        m1_ack_o = s_ack_i & own_stb;
                    end else begin
                        m0_ack_o = s_ack_i & own_stb;
                    end
                    if (!own_cyc) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_ABORT: begin
                // Bus stays released until the aborted owner ends its cycle.
                gnt_o[OWNER_M0] = !sel_m1;
                gnt_o[OWNER_M1] = sel_m1;
                if (!own_cyc) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter: a vector table for grant/mux/ack
// behaviour plus hand-written timeout, reset and fixed-priority sequences.
module tb_wb_master_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_cyc, m0_stb, m0_we;
    logic [15:0] m0_adr;
    logic [31:0] m0_dat;
    logic        m1_cyc, m1_stb, m1_we;
    logic [15:0] m1_adr;
    logic [31:0] m1_dat;
    logic [31:0] s_dat_in;
    logic        s_ack;

    logic [31:0] m0_dat_out, m1_dat_out, s_dat_out;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic        s_cyc, s_stb, s_we, timeout;
    logic [15:0] s_adr;
    logic [1:0]  gnt;

    logic [31:0] fp_m0_dat_out, fp_m1_dat_out, fp_s_dat_out;
    logic        fp_m0_ack, fp_m0_err, fp_m1_ack, fp_m1_err;
    logic        fp_s_cyc, fp_s_stb, fp_s_we, fp_timeout;
    logic [15:0] fp_s_adr;
    logic [1:0]  fp_gnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]  cyc;
        logic [1:0]  stb;
        logic [1:0]  we;
        logic [15:0] adr0;
        logic [15:0] adr1;
        logic [31:0] dat0;
        logic [31:0] dat1;
        logic        ack;
        logic [1:0]  exp_gnt;
        logic [2:0]  exp_ctrl;
        logic [15:0] exp_adr;
        logic [31:0] exp_dat;
        logic [1:0]  exp_ack;
    } vec_t;

    vec_t vecs[$];

    wb_master_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(16), .TIMEOUT_CYCLES(8), .FIXED_PRIORITY(0)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
        .m0_dat_i(m0_dat), .m0_dat_o(m0_dat_out), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
        .m1_dat_i(m1_dat), .m1_dat_o(m1_dat_out), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
        .s_dat_o(s_dat_out), .s_dat_i(s_dat_in), .s_ack_i(s_ack),
        .gnt_o(gnt), .timeout_o(timeout)
    );

    wb_master_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(16), .TIMEOUT_CYCLES(8), .FIXED_PRIORITY(1)
    ) dut_fp (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
        .m0_dat_i(m0_dat), .m0_dat_o(fp_m0_dat_out), .m0_ack_o(fp_m0_ack), .m0_err_o(fp_m0_err),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
        .m1_dat_i(m1_dat), .m1_dat_o(fp_m1_dat_out), .m1_ack_o(fp_m1_ack), .m1_err_o(fp_m1_err),
        .s_cyc_o(fp_s_cyc), .s_stb_o(fp_s_stb), .s_we_o(fp_s_we), .s_adr_o(fp_s_adr),
        .s_dat_o(fp_s_dat_out), .s_dat_i(s_dat_in), .s_ack_i(s_ack),
        .gnt_o(fp_gnt), .timeout_o(fp_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [1:0] cyc, input logic [1:0] stb,
                                input logic [1:0] we, input logic [15:0] adr0,
                                input logic [15:0] adr1, input logic [31:0] dat0,
                                input logic [31:0] dat1, input logic ack,
                                input logic [1:0] exp_gnt, input logic [2:0] exp_ctrl,
                                input logic [15:0] exp_adr, input logic [31:0] exp_dat,
                                input logic [1:0] exp_ack);
        vec_t v;
        v.cyc = cyc; v.stb = stb; v.we = we;
        v.adr0 = adr0; v.adr1 = adr1; v.dat0 = dat0; v.dat1 = dat1; v.ack = ack;
        v.exp_gnt = exp_gnt; v.exp_ctrl = exp_ctrl; v.exp_adr = exp_adr;
        v.exp_dat = exp_dat; v.exp_ack = exp_ack;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        m0_cyc = v.cyc[0]; m0_stb = v.stb[0]; m0_we = v.we[0];
        m0_adr = v.adr0;   m0_dat = v.dat0;
        m1_cyc = v.cyc[1]; m1_stb = v.stb[1]; m1_we = v.we[1];
        m1_adr = v.adr1;   m1_dat = v.dat1;
        s_ack    = v.ack;
        s_dat_in = {16'hA5A5, v.adr0 ^ v.adr1};
    endtask

    task automatic clear_inputs();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat = '0;
        s_ack = 0; s_dat_in = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_output("rst_gnt", 32'(gnt), 32'h0);
        check_output("rst_ctrl", 32'({s_cyc, s_stb, s_we}), 32'h0);
        check_output("rst_adr_dat", 32'(s_adr) | s_dat_out, 32'h0);
        check_output("rst_term", 32'({m0_ack, m0_err, m1_ack, m1_err, timeout}), 32'h0);
        check_output("rst_fp_gnt", 32'(fp_gnt), 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();

        // Single m0 write, round-robin contention, held cyc with m1 stalled
        vecs.push_back(mk(2'b01, 2'b01, 2'b01, 16'h0010, 16'h0, 32'hDEADBEEF, 32'h0, 0, 2'b00, 3'b000, 16'h0000, 32'h0, 2'b00));
        vecs.push_back(mk(2'b01, 2'b01, 2'b01, 16'h0010, 16'h0, 32'hDEADBEEF, 32'h0, 0, 2'b01, 3'b111, 16'h0010, 32'hDEADBEEF, 2'b00));
        vecs.push_back(mk(2'b01, 2'b01, 2'b01, 16'h0010, 16'h0, 32'hDEADBEEF, 32'h0, 0, 2'b01, 3'b111, 16'h0010, 32'hDEADBEEF, 2'b00));
        vecs.push_back(mk(2'b01, 2'b01, 2'b01, 16'h0010, 16'h0, 32'hDEADBEEF, 32'h0, 1, 2'b01, 3'b111, 16'h0010, 32'hDEADBEEF, 2'b01));
        vecs.push_back(mk(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0, 32'h0, 32'h0, 0, 2'b01, 3'b000, 16'h0000, 32'h0, 2'b00));
        vecs.push_back(mk(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0, 32'h0, 32'h0, 0, 2'b00, 3'b000, 16'h0000, 32'h0, 2'b00));
        vecs.push_back(mk(2'b11, 2'b11, 2'b10, 16'h0020, 16'h0100, 32'h0, 32'h12345678, 0, 2'b00, 3'b000, 16'h0000, 32'h0, 2'b00));
        vecs.push_back(mk(2'b11, 2'b11, 2'b10, 16'h0020, 16'h0100, 32'h0, 32'h12345678, 1, 2'b10, 3'b111, 16'h0100, 32'h12345678, 2'b10));
        vecs.push_back(mk(2'b01, 2'b01, 2'b00, 16'h0020, 16'h0100, 32'h0, 32'h12345678, 0, 2'b10, 3'b000, 16'h0100, 32'h12345678, 2'b00));
        vecs.push_back(mk(2'b01, 2'b01, 2'b00, 16'h0020, 16'h0100, 32'h0, 32'h12345678, 0, 2'b00, 3'b000, 16'h0000, 32'h0, 2'b00));
        vecs.push_back(mk(2'b01, 2'b01, 2'b00, 16'h0020, 16'h0100, 32'h0, 32'h12345678, 1, 2'b01, 3'b110, 16'h0020, 32'h0, 2'b01));
        vecs.push_back(mk(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0, 32'h0, 32'h0, 0, 2'b01, 3'b000, 16'h0000, 32'h0, 2'b00));
        vecs.push_back(mk(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0, 32'h0, 32'h0, 0, 2'b00, 3'b000, 16'h0000, 32'h0, 2'b00));
        vecs.push_back(mk(2'b01, 2'b01, 2'b00, 16'h0000, 16'h0, 32'h0, 32'h0, 0, 2'b00, 3'b000, 16'h0000, 32'h0, 2'b00));
        vecs.push_back(mk(2'b11, 2'b11, 2'b00, 16'h0000, 16'h0200, 32'h0, 32'h0, 1, 2'b01, 3'b110, 16'h0000, 32'h0, 2'b01));
        vecs.push_back(mk(2'b11, 2'b11, 2'b00, 16'h0001, 16'h0200, 32'h0, 32'h0, 1, 2'b01, 3'b110, 16'h0001, 32'h0, 2'b01));
        vecs.push_back(mk(2'b11, 2'b11, 2'b00, 16'h0002, 16'h0200, 32'h0, 32'h0, 1, 2'b01, 3'b110, 16'h0002, 32'h0, 2'b01));
        vecs.push_back(mk(2'b11, 2'b11, 2'b00, 16'h0003, 16'h0200, 32'h0, 32'h0, 1, 2'b01, 3'b110, 16'h0003, 32'h0, 2'b01));
        vecs.push_back(mk(2'b10, 2'b10, 2'b00, 16'h0000, 16'h0200, 32'h0, 32'h0, 0, 2'b01, 3'b000, 16'h0000, 32'h0, 2'b00));
        vecs.push_back(mk(2'b10, 2'b10, 2'b00, 16'h0000, 16'h0200, 32'h0, 32'h0, 0, 2'b00, 3'b000, 16'h0000, 32'h0, 2'b00));
        vecs.push_back(mk(2'b10, 2'b10, 2'b00, 16'h0000, 16'h0200, 32'h0, 32'h0, 0, 2'b10, 3'b110, 16'h0200, 32'h0, 2'b00));
        vecs.push_back(mk(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0, 32'h0, 32'h0, 0, 2'b10, 3'b000, 16'h0000, 32'h0, 2'b00));
        vecs.push_back(mk(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0, 32'h0, 32'h0, 0, 2'b00, 3'b000, 16'h0000, 32'h0, 2'b00));

        do_reset();
        foreach (vecs[i]) begin
            @(negedge clk);
            apply_stimulus(vecs[i]);
            #1;
            check_output($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].exp_gnt));
            check_output($sformatf("v%0d_ctrl", i), 32'({s_cyc, s_stb, s_we}), 32'(vecs[i].exp_ctrl));
            check_output($sformatf("v%0d_adr", i), 32'(s_adr), 32'(vecs[i].exp_adr));
            check_output($sformatf("v%0d_wdat", i), s_dat_out, vecs[i].exp_dat);
            check_output($sformatf("v%0d_ack", i), 32'({m1_ack, m0_ack}), 32'(vecs[i].exp_ack));
            check_output($sformatf("v%0d_err", i), 32'({m1_err, m0_err, timeout}), 32'h0);
            if (vecs[i].exp_ack[0]) check_output($sformatf("v%0d_rdat0", i), m0_dat_out, s_dat_in);
            if (vecs[i].exp_ack[1]) check_output($sformatf("v%0d_rdat1", i), m1_dat_out, s_dat_in);
        end

        // Watchdog fires on the 8th stalled cycle, then ABORT until m1 drops cyc
        do_reset();
        @(negedge clk);
        m1_cyc = 1; m1_stb = 1; m1_adr = 16'h0300;
        #1;
        check_output("to_idle_gnt", 32'(gnt), 32'h0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            #1;
            if (k == 1) check_output("to_gnt", 32'(gnt), 32'h2);
            check_output($sformatf("to_k%0d_err", k), 32'({m1_err, timeout}), (k == 8) ? 32'h3 : 32'h0);
            check_output($sformatf("to_k%0d_ack", k), 32'(m1_ack), 32'h0);
        end
        @(negedge clk);
        #1;
        check_output("abort_ctrl", 32'({s_cyc, s_stb}), 32'h0);
        check_output("abort_err", 32'({m1_err, timeout}), 32'h0);
        @(negedge clk);
        #1;
        check_output("abort_hold_cyc", 32'(s_cyc), 32'h0);
        @(negedge clk);
        m1_cyc = 0; m1_stb = 0;
        @(negedge clk);
        m0_cyc = 1; m0_stb = 1; m0_adr = 16'h0040;
        #1;
        check_output("abort_idle_gnt", 32'(gnt), 32'h0);
        @(negedge clk);
        #1;
        check_output("abort_regrant", 32'(gnt), 32'h1);
        check_output("abort_regrant_adr", 32'(s_adr), 32'h0040);

        // Ack on the limit cycle beats the timeout
        do_reset();
        @(negedge clk);
        m1_cyc = 1; m1_stb = 1; m1_adr = 16'h0304;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            s_ack = (k == 8);
            #1;
            if (k == 8) begin
                check_output("race_ack", 32'(m1_ack), 32'h1);
                check_output("race_err", 32'({m1_err, timeout}), 32'h0);
            end
        end
        @(negedge clk);
        s_ack = 0;
        #1;
        check_output("race_still_owned", 32'({gnt, s_cyc}), 32'h5);
        check_output("race_no_timeout", 32'(timeout), 32'h0);

        // Asynchronous reset in the middle of an m0 transfer
        do_reset();
        @(negedge clk);
        m0_cyc = 1; m0_stb = 1; m0_adr = 16'h0050;
        @(negedge clk);
        #1;
        check_output("arst_pre", 32'({gnt, s_cyc}), 32'h3);
        #2;
        rst = 1;
        #1;
        check_output("arst_gnt", 32'(gnt), 32'h0);
        check_output("arst_ctrl", 32'({s_cyc, s_stb}), 32'h0);
        @(negedge clk);
        rst = 0;
        #1;
        check_output("arst_idle", 32'(gnt), 32'h0);
        @(negedge clk);
        #1;
        check_output("arst_regrant", 32'(gnt), 32'h1);
        check_output("arst_adr", 32'(s_adr), 32'h0050);

        // Fixed priority: m0 wins every simultaneous request
        do_reset();
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
            #1;
            check_output($sformatf("fp_r%0d_idle", r), 32'(fp_gnt), 32'h0);
            @(negedge clk);
            #1;
            check_output($sformatf("fp_r%0d_gnt", r), 32'(fp_gnt), 32'h1);
            @(negedge clk);
            m0_cyc = 0; m0_stb = 0;
        end
        @(negedge clk);
        clear_inputs();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
